// File: rtl/vga_timing_pkg.sv
// rtl/vga_timing_pkg.sv - shared 640x480@60 VGA timing constants and frame buffer geometry
// Used by the VGA read side and by the UART write-address counter.
package vga_timing_pkg;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  localparam int FRAME_PIXELS = H_VISIBLE * V_VISIBLE;
  localparam int ADDR_W       = 19;
  localparam int CNT_W        = 10;

  // Negative-polarity sync level: 0 while cnt lies inside [start, start+len).
  function automatic logic sync_level(input int cnt, input int start, input int len);
    return !((cnt >= start) && (cnt < start + len));
  endfunction

endpackage

// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - pixel enable, h/v counters, raw syncs and frame marker
// Ports:
//   clk         in   system clock (CLOCK_50)
//   rst_n       in   asynchronous reset, active-low
//   pix_tick    out  pixel enable, high on every second clk
//   h_cnt       out  horizontal position 0..H_TOTAL-1
//   v_cnt       out  vertical position 0..V_TOTAL-1
//   active      out  counters inside the visible area
//   hs_raw      out  undelayed horizontal sync, active-low
//   vs_raw      out  undelayed vertical sync, active-low
//   frame_start out  one-clk pulse on the clk after the tick at h=0, v=0
module vga_timing_gen
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE = vga_timing_pkg::H_VISIBLE,
  parameter int V_VISIBLE = vga_timing_pkg::V_VISIBLE
) (
  input  logic             clk,
  input  logic             rst_n,
  output logic             pix_tick,
  output logic [CNT_W-1:0] h_cnt,
  output logic [CNT_W-1:0] v_cnt,
  output logic             active,
  output logic             hs_raw,
  output logic             vs_raw,
  output logic             frame_start
);

  localparam logic [CNT_W-1:0] H_LAST = CNT_W'(H_VISIBLE + H_FP + H_SYNC + H_BP - 1);
  localparam logic [CNT_W-1:0] V_LAST = CNT_W'(V_VISIBLE + V_FP + V_SYNC + V_BP - 1);

  logic             pix_q;
  logic [CNT_W-1:0] h_q;
  logic [CNT_W-1:0] v_q;
  logic             fs_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pix_q <= 1'b0;
      h_q   <= '0;
      v_q   <= '0;
      fs_q  <= 1'b0;
    end else begin
      pix_q <= ~pix_q;
      fs_q  <= pix_q && (h_q == '0) && (v_q == '0);
      if (pix_q) begin
        if (h_q == H_LAST) begin
          h_q <= '0;
          v_q <= (v_q == V_LAST) ? '0 : v_q + 1'b1;
        end else begin
          h_q <= h_q + 1'b1;
        end
      end
    end
  end

  assign pix_tick    = pix_q;
  assign h_cnt       = h_q;
  assign v_cnt       = v_q;
  assign frame_start = fs_q;
  assign active      = (int'(h_q) < H_VISIBLE) && (int'(v_q) < V_VISIBLE);
  assign hs_raw      = sync_level(int'(h_q), H_VISIBLE + H_FP, H_SYNC);
  assign vs_raw      = sync_level(int'(v_q), V_VISIBLE + V_FP, V_SYNC);

endmodule

// File: rtl/vga_frame_reader.sv
// rtl/vga_frame_reader.sv - frame buffer read side driving the DE1-SoC VGA DAC
// Ports:
//   clk         in   50 MHz system clock (CLOCK_50)
//   rst_n       in   asynchronous reset, active-low
//   video_en    in   1 = show frame buffer, 0 = black with timing running
//   rd_addr     out  BRAM read address, 0..H_VISIBLE*V_VISIBLE-1
//   pixel_data  in   BRAM q, grayscale, valid RD_LATENCY clk after rd_addr
//   vga_r/g/b   out  DAC colour channels
//   vga_hs/vs   out  syncs, active-low
//   vga_blank_n out  low outside the active area
//   vga_sync_n  out  tied 0
//   vga_clk     out  25 MHz DAC clock, rises mid-way through stable data
//   frame_start out  one-clk frame marker for the write side
module vga_frame_reader
  import vga_timing_pkg::*;
#(
  parameter int RD_LATENCY = 2,
  parameter int H_VISIBLE  = vga_timing_pkg::H_VISIBLE,
  parameter int V_VISIBLE  = vga_timing_pkg::V_VISIBLE
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              video_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [7:0]        pixel_data,
  output logic [7:0]        vga_r,
  output logic [7:0]        vga_g,
  output logic [7:0]        vga_b,
  output logic              vga_hs,
  output logic              vga_vs,
  output logic              vga_blank_n,
  output logic              vga_sync_n,
  output logic              vga_clk,
  output logic              frame_start
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(H_VISIBLE * V_VISIBLE - 1);

  logic             pix_tick;
  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  logic             active;
  logic             hs_raw;
  logic             vs_raw;

  vga_timing_gen #(
    .H_VISIBLE (H_VISIBLE),
    .V_VISIBLE (V_VISIBLE)
  ) u_timing (
    .clk         (clk),
    .rst_n       (rst_n),
    .pix_tick    (pix_tick),
    .h_cnt       (h_cnt),
    .v_cnt       (v_cnt),
    .active      (active),
    .hs_raw      (hs_raw),
    .vs_raw      (vs_raw),
    .frame_start (frame_start)
  );

  // Incremental address: the value after a tick is the address of the pixel
  // the counters showed on that tick; blanking holds it so lines abut.
  logic [ADDR_W-1:0] addr_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q <= '0;
    end else if (pix_tick) begin
      if ((h_cnt == '0) && (v_cnt == '0)) begin
        addr_q <= '0;
      end else if (active && (addr_q != LAST_ADDR)) begin
        addr_q <= addr_q + 1'b1;
      end
    end
  end

  assign rd_addr = addr_q;

  // 1 clk for the address register plus RD_LATENCY for the BRAM.
  logic [RD_LATENCY:0] act_sr;
  logic [RD_LATENCY:0] hs_sr;
  logic [RD_LATENCY:0] vs_sr;
  logic [RD_LATENCY:0] tick_sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      act_sr  <= '0;
      hs_sr   <= '1;
      vs_sr   <= '1;
      tick_sr <= '0;
    end else begin
      act_sr  <= {act_sr[RD_LATENCY-1:0], active};
      hs_sr   <= {hs_sr[RD_LATENCY-1:0], hs_raw};
      vs_sr   <= {vs_sr[RD_LATENCY-1:0], vs_raw};
      tick_sr <= {tick_sr[RD_LATENCY-1:0], pix_tick};
    end
  end

  logic       tick_d;
  logic [7:0] grey_q;
  logic       blank_n_q;
  logic       hs_q;
  logic       vs_q;
  logic       vclk_q;

  assign tick_d = tick_sr[RD_LATENCY];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      grey_q    <= 8'd0;
      blank_n_q <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      vclk_q    <= 1'b0;
    end else begin
      // DAC clock falls with the load and rises one clk later.
      vclk_q <= !tick_d;
      if (tick_d) begin
        grey_q    <= (act_sr[RD_LATENCY] && video_en) ? pixel_data : 8'd0;
        blank_n_q <= act_sr[RD_LATENCY];
        hs_q      <= hs_sr[RD_LATENCY];
        vs_q      <= vs_sr[RD_LATENCY];
      end
    end
  end

  assign vga_r       = grey_q;
  assign vga_g       = grey_q;
  assign vga_b       = grey_q;
  assign vga_blank_n = blank_n_q;
  assign vga_hs      = hs_q;
  assign vga_vs      = vs_q;
  assign vga_clk     = vclk_q;
  assign vga_sync_n  = 1'b0;

endmodule
